uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Samples the serial line at
//  OVS x baud using an external tick. Supports configurable data width, optional odd or even
//  parity, and 1 or 2 stop bits. Adds line synchronisation, false-start rejection, 3-sample
//  majority voting, parity/framing error flags and break handling. Sits between the baud-rate
//  tick generator and the UART RX FIFO/interface.
// PARAMETERS
//  DBIT       8   data bits per frame, 5..9, sent LSB first
//  OVS        16  ticks per bit, even, 8..32; counter width $clog2(OVS)
//  PARITY     0   0 = none, 1 = odd, 2 = even
//  STOP_BITS  1   number of stop bits checked, 1 or 2
// PORTS
//  i_clk          in   1     system clock, rising edge
//  i_rst          in   1     asynchronous reset, active-low
//  i_bit          in   1     raw serial line, idle high, asynchronous to i_clk
//  i_tick         in   1     1-cycle oversampling strobe, OVS per bit period
//  o_data         out  DBIT  last received word, held until the next o_done_data
//  o_done_data    out  1     1-cycle pulse: frame complete, o_data and error flags valid
//  o_parity_err   out  1     parity mismatch on the last frame, 0 if PARITY == 0
//  o_frame_err    out  1     a stop bit was sampled low on the last frame
//  o_busy         out  1     high in every state other than IDLE
// BEHAVIOUR
//  - Reset (i_rst low, async): state = IDLE, all counters 0, o_data = 0, all flags/pulses 0.
//    Both synchroniser flops are set to 1, so no false start is seen on release.
//  - Reset mid-frame aborts the frame; o_done_data does not fire for a partial frame.
//  - i_bit passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//  - FSM states: IDLE, START, DATA, PAR, STOP, BRK.
//  - IDLE: rx_s == 0 -> START, s = 0 (tick not required).
//  - START: on each tick s++. At s == OVS/2-1:
//      rx_s == 1 -> IDLE (glitch rejected, no flags set).
//      rx_s == 0 -> DATA, s = 0, n = 0.
//  - Sample point: every subsequent bit is decided at the tick where s == OVS-1 (mid-bit).
//    The bit value is the majority of rx_s captured at s == OVS-3, OVS-2 and OVS-1.
//  - DATA: at the sample point, shift the bit into the MSB of the shift register and set s = 0.
//    After n == DBIT-1: go to PAR if PARITY != 0, else go to STOP. Otherwise n++.
//    After DBIT bits, the first-received bit sits at bit 0.
//  - PAR: at the sample point:
//      perr = (^data ^ bit) != (PARITY == 1)  (odd: total count of 1s must be odd).
//    Then -> STOP, s = 0, k = 0.
//  - STOP: at each sample point, a low stop bit sets ferr.
//      k < STOP_BITS-1: k++, s = 0, stay in STOP.
//      Last stop bit: o_data <= shift register, o_parity_err <= perr, o_frame_err <= ferr,
//      o_done_data = 1 for exactly one cycle (registered, the cycle after that tick edge).
//      Next state -> IDLE if the sampled stop bit is 1, else -> BRK.
//  - BRK: wait for rx_s == 1, then -> IDLE. No re-trigger on a held-low line or break.
//  - Ticks arriving while in IDLE or BRK are ignored. With no ticks, the FSM holds its state.
//  - Frame latency: o_done_data fires 2 clocks + (OVS/2 + (1+DBIT+P+STOP_BITS-1)*OVS) ticks
//    after the falling edge, where P = 1 if PARITY != 0 else 0.
//  - Flags and o_data change only when o_done_data fires; they hold between frames.
//  - Back-to-back frames: a start edge detected in the half-bit after the stop sample is accepted.
// TESTING  (DBIT=8, OVS=16, tick every 4 clocks unless noted)
//  1. PARITY=0, STOP_BITS=1, send 0xA5 -> one o_done_data pulse, o_data = 0xA5, both flags 0.
//  2. PARITY=2, send 0x07 with parity bit 1 -> o_data = 0x07, perr 0.
//     Same frame with parity bit 0 -> perr 1.
//  3. Stop bit driven low, send 0x3C -> o_frame_err 1, FSM in BRK.
//     Hold the line low 5 bit times: no new done pulse. Release high, then send 0x55:
//     o_data = 0x55, ferr 0.
//  4. Line low for 5 ticks, then high -> returns to IDLE, no done pulse, o_busy drops.
//  5. 1-tick low glitch at the middle of data bit 3 of 0xFF -> majority vote keeps it 1,
//     o_data = 0xFF.
//  6. Assert i_rst during data bit 4 -> outputs 0 immediately. Release, then send 0x81 ->
//     o_data = 0x81.
//     STOP_BITS=2, send 0x81 back-to-back twice -> two done pulses, both 0x81.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Parametrised UART receiver. The raw serial line is resynchronised, then
// sampled at OVS ticks per bit using an externally generated oversampling
// strobe. Each bit after the start bit is decided at mid-bit by a 3-sample
// majority vote. Frames carry DBIT data bits (LSB first), an optional odd or
// even parity bit and STOP_BITS stop bits. A stop bit sampled low flags a
// framing error; if the final stop bit is low the receiver parks in a break
// state until the line returns high, so a held-low line never re-triggers.
//
// Parameters
//   DBIT       data bits per frame (5..9)
//   OVS        ticks per bit period (even, 8..32)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  number of stop bits checked (1 or 2)
//
// Ports
//   i_clk         in   system clock, rising edge
//   i_rst         in   asynchronous reset, active-low
//   i_bit         in   raw serial line, idle high, asynchronous to i_clk
//   i_tick        in   one-cycle oversampling strobe, OVS per bit period
//   o_data        out  last received word, held until the next o_done_data
//   o_done_data   out  one-cycle pulse: frame complete, data and flags valid
//   o_parity_err  out  parity mismatch on the last frame (0 without parity)
//   o_frame_err   out  a stop bit was sampled low on the last frame
//   o_busy        out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DBIT      = 8,
    parameter int OVS       = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_bit,
    input  logic            i_tick,
    output logic [DBIT-1:0] o_data,
    output logic            o_done_data,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_busy
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DBIT);

    // Tick-counter landmarks within one bit period.
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);
    localparam logic [SW-1:0] CNT_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] CNT_V0   = SW'(OVS - 3);
    localparam logic [SW-1:0] CNT_V1   = SW'(OVS - 2);
    localparam logic [SW-1:0] CNT_LAST = SW'(OVS - 1);

    localparam logic [NW-1:0] BIT_ONE  = NW'(1);
    localparam logic [NW-1:0] BIT_LAST = NW'(DBIT - 1);

    // The stop-bit counter only ever needs to distinguish first from second.
    localparam logic STOP_LAST = (STOP_BITS == 2);
    localparam logic HAS_PAR   = (PARITY != 0);
    localparam logic ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BRK
    } state_t;

    // Two-of-three vote over the samples taken just before and at mid-bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Line synchroniser
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    // Receiver state
    state_t          state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic            k_q;
    logic [DBIT-1:0] sh_q;
    logic            v0_q;
    logic            v1_q;
    logic            perr_q;
    logic            ferr_q;

    // Registered outputs
    logic [DBIT-1:0] data_q;
    logic            done_q;
    logic            perr_out_q;
    logic            ferr_out_q;

    // Combinational helpers for the sample point
    logic samp_d;
    logic bit_d;
    logic ferr_d;
    logic perr_d;
    logic in_bit_d;

    // Both flops preset high so a released reset looks like an idle line.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_bit;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_comb begin
        in_bit_d = (state_q == ST_DATA) || (state_q == ST_PAR) || (state_q == ST_STOP);
        samp_d   = i_tick && in_bit_d && (s_q == CNT_LAST);
        bit_d    = maj3(v0_q, v1_q, rx_s);
        ferr_d   = ferr_q | ~bit_d;
        // Total count of ones over data plus parity bit: odd parity needs it odd.
        perr_d   = ((^sh_q) ^ bit_d) != ODD_PAR;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            k_q        <= 1'b0;
            sh_q       <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // The two early votes are captured on the ticks just before mid-bit.
            if (i_tick && in_bit_d) begin
                if (s_q == CNT_V0) begin
                    v0_q <= rx_s;
                end
                if (s_q == CNT_V1) begin
                    v1_q <= rx_s;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end

                // Half a bit in: a line that is high again was only a glitch.
                ST_START: begin
                    if (i_tick) begin
                        if (s_q == CNT_HALF) begin
                            if (rx_s) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                                perr_q  <= 1'b0;
                                ferr_q  <= 1'b0;
                            end
                        end else begin
                            s_q <= s_q + CNT_ONE;
                        end
                    end
                end

                // LSB arrives first, so shifting in at the top leaves it at bit 0.
                ST_DATA: begin
                    if (samp_d) begin
                        sh_q <= {bit_d, sh_q[DBIT-1:1]};
                        s_q  <= '0;
                        if (n_q == BIT_LAST) begin
                            if (HAS_PAR) begin
                                state_q <= ST_PAR;
                            end else begin
                                state_q <= ST_STOP;
                                k_q     <= 1'b0;
                            end
                        end else begin
                            n_q <= n_q + BIT_ONE;
                        end
                    end else if (i_tick) begin
                        s_q <= s_q + CNT_ONE;
                    end
                end

                ST_PAR: begin
                    if (samp_d) begin
                        perr_q  <= perr_d;
                        state_q <= ST_STOP;
                        s_q     <= '0;
                        k_q     <= 1'b0;
                    end else if (i_tick) begin
                        s_q <= s_q + CNT_ONE;
                    end
                end

                // A low final stop bit means the line may be in break: park in
                // ST_BRK so a held-low line cannot start a phantom frame.
                ST_STOP: begin
                    if (samp_d) begin
                        if (k_q != STOP_LAST) begin
                            k_q    <= 1'b1;
                            s_q    <= '0;
                            ferr_q <= ferr_d;
                        end else begin
                            data_q     <= sh_q;
                            perr_out_q <= perr_q;
                            ferr_out_q <= ferr_d;
                            ferr_q     <= ferr_d;
                            done_q     <= 1'b1;
                            s_q        <= '0;
                            state_q    <= bit_d ? ST_IDLE : ST_BRK;
                        end
                    end else if (i_tick) begin
                        s_q <= s_q + CNT_ONE;
                    end
                end

                ST_BRK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_done_data  = done_q;
    assign o_parity_err = perr_out_q;
    assign o_frame_err  = ferr_out_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Bench for uart_rx_cfg. Three receivers are instantiated (8N1, 8E1, 8N2),
// each on its own serial line with a shared clock, tick and reset. Stimulus
// pushes the expected frame result into a per-receiver queue; a monitor per
// receiver pops and compares on every o_done_data pulse, and any pulse with an
// empty queue is reported as unexpected.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic tick  = 1'b0;
    logic line0 = 1'b1;
    logic line1 = 1'b1;
    logic line2 = 1'b1;

    logic [7:0] d0, d1, d2;
    logic       dn0, dn1, dn2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       bz0, bz1, bz2;

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    // One tick every fourth clock.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = (tick_cnt % 4 == 3);
            tick_cnt++;
        end
    end

    uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .i_clk(clk), .i_rst(rst_n), .i_bit(line0), .i_tick(tick),
        .o_data(d0), .o_done_data(dn0), .o_parity_err(pe0),
        .o_frame_err(fe0), .o_busy(bz0)
    );

    uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .i_clk(clk), .i_rst(rst_n), .i_bit(line1), .i_tick(tick),
        .o_data(d1), .o_done_data(dn1), .o_parity_err(pe1),
        .o_frame_err(fe1), .o_busy(bz1)
    );

    uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .i_clk(clk), .i_rst(rst_n), .i_bit(line2), .i_tick(tick),
        .o_data(d2), .o_done_data(dn2), .o_parity_err(pe2),
        .o_frame_err(fe2), .o_busy(bz2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cmp_frame(input string tag, input bit have, input exp_t e,
                             input logic [7:0] d, input logic pe, input logic fe);
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.unexpected_done: got data=%0h pe=%0b fe=%0b, expected no pulse",
                     tag, d, pe, fe);
        end else begin
            chk({tag, ".data"}, {24'd0, d}, {24'd0, e.d});
            chk({tag, ".perr"}, {31'd0, pe}, {31'd0, e.pe});
            chk({tag, ".ferr"}, {31'd0, fe}, {31'd0, e.fe});
        end
    endtask

    always @(negedge clk) begin
        if (dn0) begin
            exp_t e;
            bit   h;
            e = '0;
            h = (q0.size() != 0);
            if (h) e = q0.pop_front();
            cmp_frame("n1", h, e, d0, pe0, fe0);
        end
    end

    always @(negedge clk) begin
        if (dn1) begin
            exp_t e;
            bit   h;
            e = '0;
            h = (q1.size() != 0);
            if (h) e = q1.pop_front();
            cmp_frame("e1", h, e, d1, pe1, fe1);
        end
    end

    always @(negedge clk) begin
        if (dn2) begin
            exp_t e;
            bit   h;
            e = '0;
            h = (q2.size() != 0);
            if (h) e = q2.pop_front();
            cmp_frame("n2", h, e, d2, pe2, fe2);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int w, input logic v);
        case (w)
            0:       line0 = v;
            1:       line1 = v;
            default: line2 = v;
        endcase
    endtask

    task automatic push_exp(input int w, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        case (w)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // One bit = 16 ticks = 64 clocks. par < 0 means no parity bit.
    // gidx selects a frame bit (0 = start) that is sent high with a one-tick
    // low glitch landing on its mid-bit tick. The line is left at the last bit.
    task automatic send_frame(input int w, input logic [7:0] d, input int par,
                              input logic [1:0] stp, input int nstop, input int gidx);
        logic [15:0] fb;
        int          nb;
        fb = '0;
        nb = 0;
        fb[nb] = 1'b0;
        nb++;
        for (int i = 0; i < 8; i++) begin
            fb[nb] = d[i];
            nb++;
        end
        if (par >= 0) begin
            fb[nb] = par[0];
            nb++;
        end
        for (int i = 0; i < nstop; i++) begin
            fb[nb] = stp[i];
            nb++;
        end
        @(posedge clk iff tick);
        #1;
        for (int i = 0; i < nb; i++) begin
            if (i == gidx) begin
                set_line(w, 1'b1);
                step(29);
                set_line(w, 1'b0);
                step(4);
                set_line(w, 1'b1);
                step(31);
            end else begin
                set_line(w, fb[i]);
                step(64);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        step(5);
        chk("rst.data", {24'd0, d0}, 32'd0);
        chk("rst.done", {31'd0, dn0}, 32'd0);
        chk("rst.perr", {31'd0, pe0}, 32'd0);
        chk("rst.ferr", {31'd0, fe0}, 32'd0);
        chk("rst.busy", {31'd0, bz0}, 32'd0);
        rst_n = 1'b1;
        step(10);

        // Plain 8N1 frame
        push_exp(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, -1, 2'b01, 1, -1);
        step(20);

        // Low stop bit, then a held-low line: one pulse, then break
        push_exp(0, 8'h3C, 1'b0, 1'b1);
        send_frame(0, 8'h3C, -1, 2'b00, 1, -1);
        step(5 * 64);
        chk("brk.busy_held", {31'd0, bz0}, 32'd1);
        set_line(0, 1'b1);
        step(64);
        chk("brk.busy_released", {31'd0, bz0}, 32'd0);
        push_exp(0, 8'h55, 1'b0, 1'b0);
        send_frame(0, 8'h55, -1, 2'b01, 1, -1);
        step(20);

        // Short low pulse rejected at the half-bit check
        @(posedge clk iff tick);
        #1;
        set_line(0, 1'b0);
        step(20);
        set_line(0, 1'b1);
        chk("glitch_start.busy", {31'd0, bz0}, 32'd1);
        step(40);
        chk("glitch_start.idle", {31'd0, bz0}, 32'd0);
        step(20);

        // One-tick glitch on data bit 3 of 0xFF outvoted by the other two samples
        push_exp(0, 8'hFF, 1'b0, 1'b0);
        send_frame(0, 8'hFF, -1, 2'b01, 1, 4);
        step(20);

        // Reset during data bit 4 of 0x81 aborts the frame
        @(posedge clk iff tick);
        #1;
        set_line(0, 1'b0);
        step(64);
        for (int i = 0; i < 4; i++) begin
            set_line(0, (i == 0) ? 1'b1 : 1'b0);
            step(64);
        end
        set_line(0, 1'b0);
        step(32);
        rst_n = 1'b0;
        #1;
        chk("midrst.data", {24'd0, d0}, 32'd0);
        chk("midrst.busy", {31'd0, bz0}, 32'd0);
        chk("midrst.done", {31'd0, dn0}, 32'd0);
        step(3);
        set_line(0, 1'b1);
        step(5);
        rst_n = 1'b1;
        step(64);
        push_exp(0, 8'h81, 1'b0, 1'b0);
        send_frame(0, 8'h81, -1, 2'b01, 1, -1);
        step(20);

        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        push_exp(1, 8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1, 2'b01, 1, -1);
        step(20);
        push_exp(1, 8'h07, 1'b1, 1'b0);
        send_frame(1, 8'h07, 0, 2'b01, 1, -1);
        step(20);

        // Two stop bits, back-to-back frames, then a low first stop bit
        push_exp(2, 8'h81, 1'b0, 1'b0);
        push_exp(2, 8'h81, 1'b0, 1'b0);
        send_frame(2, 8'h81, -1, 2'b11, 2, -1);
        send_frame(2, 8'h81, -1, 2'b11, 2, -1);
        step(20);
        push_exp(2, 8'h5A, 1'b0, 1'b1);
        send_frame(2, 8'h5A, -1, 2'b10, 2, -1);
        step(100);

        // Every expected frame must have been delivered
        chk("n1.pending", q0.size(), 32'd0);
        chk("e1.pending", q1.size(), 32'd0);
        chk("n2.pending", q2.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
